// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] NIBBLE_ZERO = 4'h0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seven_seg_lz_mask.sv
// Leading-zero suppression mask: digit k is flagged when it and every digit above it are zero.
module seven_seg_lz_mask
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]         suppress
);

  always_comb begin
    logic zero_above;
    suppress   = '0;
    zero_above = 1'b1;
    // Digit 0 is left out of the walk so a value of zero still shows one "0".
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above && (digits[k*DIGIT_W +: DIGIT_W] == NIBBLE_ZERO);
      suppress[k] = zero_above;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode multi-digit display.
// Shadow registers decouple bus updates from the scan so a frame never tears.
//
// state | meaning
// IDLE  | scan stopped, all outputs low; shadow load acknowledged immediately
// SHOW  | digit idx lit for SHOW_CYCLES cycles
// BLANK | all digits off for BLANK_CYCLES cycles before advancing idx
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          lz_en,
  input  logic                          upd_req,
  output logic                          upd_ack,
  output logic [DIGIT_W-1:0]            dec_din,
  output logic                          dec_en,
  output logic [NUM_DIGITS-1:0]         dig_sel,
  output logic                          dp,
  output logic                          frame_done
);

  localparam int CNT_W = $clog2(max_int(SHOW_CYCLES, BLANK_CYCLES));
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t                   state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [DIGIT_W*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]         shadow_dp_q, shadow_dp_d;
  logic                          upd_ack_q, upd_ack_d;
  logic [DIGIT_W-1:0]            dec_din_q, dec_din_d;
  logic                          dec_en_q, dec_en_d;
  logic [NUM_DIGITS-1:0]         dig_sel_q, dig_sel_d;
  logic                          dp_q, dp_d;
  logic                          frame_done_q, frame_done_d;

  logic [NUM_DIGITS-1:0] suppress;
  logic                  boundary;
  logic                  capture;

  // Mask is taken from shadow_d so a frame-boundary load is honoured on its first digit.
  seven_seg_lz_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_mask (
    .digits  (shadow_d),
    .suppress(suppress)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + 1'b1;
    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    upd_ack_d    = 1'b0;
    frame_done_d = 1'b0;

    boundary = (state_q == BLANK) && (idx_q == IDX_LAST) && (cnt_q == BLANK_LAST);
    capture  = upd_req && ((state_q == IDLE) || boundary);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (en) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d      = SHOW;
          cnt_d        = '0;
          idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          frame_done_d = (idx_q == IDX_LAST);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (!en) begin
      state_d      = IDLE;
      idx_d        = '0;
      cnt_d        = '0;
      frame_done_d = 1'b0;
    end

    // A boundary load still completes when en drops on that same cycle.
    if (capture) begin
      shadow_d    = digits_in;
      shadow_dp_d = dp_in;
      upd_ack_d   = 1'b1;
    end

    dig_sel_d = '0;
    dec_din_d = '0;
    dec_en_d  = 1'b0;
    dp_d      = 1'b0;
    if (state_d == SHOW) begin
      dig_sel_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
      dec_din_d = shadow_d[idx_d*DIGIT_W +: DIGIT_W];
      dp_d      = shadow_dp_d[idx_d];
      dec_en_d  = ~(lz_en & suppress[idx_d]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      upd_ack_q    <= 1'b0;
      dec_din_q    <= '0;
      dec_en_q     <= 1'b0;
      dig_sel_q    <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      upd_ack_q    <= upd_ack_d;
      dec_din_q    <= dec_din_d;
      dec_en_q     <= dec_en_d;
      dig_sel_q    <= dig_sel_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign upd_ack    = upd_ack_q;
  assign dec_din    = dec_din_q;
  assign dec_en     = dec_en_q;
  assign dig_sel    = dig_sel_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with 4 digits, 4 show cycles and 2 blank cycles.
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int SHOWC = 4;
  localparam int BLKC  = 2;
  localparam int SLOT  = SHOWC + BLKC;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic        upd_req;
  logic        upd_ack;
  logic [3:0]  dec_din;
  logic        dec_en;
  logic [3:0]  dig_sel;
  logic        dp;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SHOW_CYCLES (SHOWC),
    .BLANK_CYCLES(BLKC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .lz_en     (lz_en),
    .upd_req   (upd_req),
    .upd_ack   (upd_ack),
    .dec_din   (dec_din),
    .dec_en    (dec_en),
    .dig_sel   (dig_sel),
    .dp        (dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] din;
    logic [3:0]  dpm;
    logic        lz;
    logic [3:0]  exp_en;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {dig_sel, dec_en, dp, dec_din} at frame cycle c (0..23).
  function automatic logic [9:0] exp_out(input int c, input logic [15:0] din,
                                         input logic [3:0] en_m, input logic [3:0] dp_m);
    int d;
    int p;
    d = c / SLOT;
    p = c % SLOT;
    if (p < SHOWC) return {4'(1 << d), en_m[d], dp_m[d], din[d*4 +: 4]};
    return 10'b0;
  endfunction

  task automatic check_cycle(input string name, input int c, input logic [15:0] din,
                             input logic [3:0] en_m, input logic [3:0] dp_m,
                             input logic exp_fd, input logic exp_ack);
    logic [11:0] exp_v;
    logic [11:0] act_v;
    int cc;
    cc    = c % FRAME;
    exp_v = {exp_out(cc, din, en_m, dp_m), exp_fd, exp_ack};
    act_v = {dig_sel, dec_en, dp, ((cc % SLOT) < SHOWC) ? dec_din : 4'h0, frame_done, upd_ack};
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s c=%0d: got {sel,en,dp,din,fd,ack}=%b required %b", name, c, act_v, exp_v);
    end
  endtask

  task automatic check_idle(input string name, input logic exp_ack);
    logic [11:0] act_v;
    act_v = {dig_sel, dec_en, dp, dec_din, frame_done, upd_ack};
    n_tests++;
    if (act_v !== {11'b0, exp_ack}) begin
      n_fail++;
      $display("FAIL %s: got {sel,en,dp,din,fd,ack}=%b required %b", name, act_v, {11'b0, exp_ack});
    end
  endtask

  task automatic load_idle(input logic [15:0] d, input logic [3:0] p);
    digits_in = d;
    dp_in     = p;
    upd_req   = 1'b1;
    tick();
    check_idle("idle_ack", 1'b1);
    upd_req = 1'b0;
    tick();
    check_idle("idle_ack_drop", 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{din: 16'h1234, dpm: 4'b0000, lz: 1'b0, exp_en: 4'b1111};
    vecs[1] = '{din: 16'h0050, dpm: 4'b1000, lz: 1'b1, exp_en: 4'b0011};
    vecs[2] = '{din: 16'h0000, dpm: 4'b0000, lz: 1'b1, exp_en: 4'b0001};
    vecs[3] = '{din: 16'h0000, dpm: 4'b0110, lz: 1'b0, exp_en: 4'b1111};
    vecs[4] = '{din: 16'h0A0F, dpm: 4'b0101, lz: 1'b1, exp_en: 4'b0111};
    vecs[5] = '{din: 16'h9000, dpm: 4'b0010, lz: 1'b1, exp_en: 4'b1111};
    vecs[6] = '{din: 16'h0050, dpm: 4'b1000, lz: 1'b0, exp_en: 4'b1111};

    rst       = 1'b1;
    en        = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    lz_en     = 1'b0;
    upd_req   = 1'b0;
    tick();
    tick();
    check_idle("in_reset", 1'b0);
    rst = 1'b0;
    tick();
    check_idle("post_reset", 1'b0);

    // Table-driven: load in IDLE, scan one full frame plus the wrap cycle, stop.
    for (int i = 0; i < 7; i++) begin
      lz_en = vecs[i].lz;
      load_idle(vecs[i].din, vecs[i].dpm);
      en = 1'b1;
      tick();
      for (int c = 0; c <= FRAME; c++) begin
        check_cycle("vector", c, vecs[i].din, vecs[i].exp_en, vecs[i].dpm, c == FRAME, 1'b0);
        if (c < FRAME) tick();
      end
      en = 1'b0;
      tick();
      check_idle("vector_stop", 1'b0);
    end

    // Mid-frame update request is held off until the frame boundary.
    lz_en = 1'b0;
    load_idle(16'h1234, 4'b0000);
    en = 1'b1;
    tick();
    for (int c = 0; c < FRAME; c++) begin
      check_cycle("midframe_old", c, 16'h1234, 4'b1111, 4'b0000, 1'b0, 1'b0);
      if (c == 8) begin
        digits_in = 16'hABCD;
        upd_req   = 1'b1;
      end
      tick();
    end
    check_cycle("boundary_ack", 0, 16'hABCD, 4'b1111, 4'b0000, 1'b1, 1'b1);
    upd_req = 1'b0;
    tick();
    for (int c = 1; c <= FRAME; c++) begin
      check_cycle("midframe_new", c, 16'hABCD, 4'b1111, 4'b0000, c == FRAME, 1'b0);
      tick();
    end

    // en dropped during digit 2 show; re-enable restarts at digit 0.
    en = 1'b0;
    tick();
    check_idle("stop_a", 1'b0);
    en = 1'b1;
    tick();
    for (int c = 0; c <= 13; c++) begin
      check_cycle("pre_off", c, 16'hABCD, 4'b1111, 4'b0000, 1'b0, 1'b0);
      if (c == 13) en = 1'b0;
      tick();
    end
    check_idle("en_off", 1'b0);
    tick();
    check_idle("en_off_hold", 1'b0);
    en = 1'b1;
    tick();
    for (int c = 0; c < FRAME; c++) begin
      check_cycle("restart", c, 16'hABCD, 4'b1111, 4'b0000, 1'b0, 1'b0);
      if (c == 20) begin
        digits_in = 16'h5678;
        dp_in     = 4'b0001;
        upd_req   = 1'b1;
      end
      if (c == FRAME - 1) en = 1'b0;
      tick();
    end
    // en fell on the boundary cycle: load still acknowledged, no frame_done.
    check_idle("boundary_en_off", 1'b1);
    upd_req = 1'b0;
    tick();
    check_idle("boundary_en_off_drop", 1'b0);
    en = 1'b1;
    tick();
    for (int c = 0; c <= 4; c++) begin
      check_cycle("after_boundary_off", c, 16'h5678, 4'b1111, 4'b0001, 1'b0, 1'b0);
      if (c < 4) tick();
    end

    // Async reset in the blank phase of digit 0.
    #3;
    rst = 1'b1;
    #1;
    check_idle("async_rst", 1'b0);
    tick();
    tick();
    check_idle("rst_held", 1'b0);
    #2;
    rst = 1'b0;
    tick();
    for (int c = 0; c < 8; c++) begin
      check_cycle("post_rst_shadow", c, 16'h0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
